iobuf_bus_ctrl: RTL and testbench



---
 rtl/iobuf_bus_ctrl.sv | 144 ++++++++++++++
 tb/tb_iobuf_bus_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/iobuf_bus_ctrl.sv
// Round-robin controller sharing one half-duplex tri-state bus between requesters A and B.
// Sequences buffer enables (T active-low), inserts turnaround on direction change; all outputs registered.
module iobuf_bus_ctrl #(
  parameter int WIDTH    = 8,
  parameter int WR_CYC   = 2,
  parameter int RD_CYC   = 2,
  parameter int TURN_CYC = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic             ack_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             ack_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] pad_o,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, TURN, DRIVE, SAMPLE} state_t;

  localparam logic [4:0] WR_LD   = 5'(WR_CYC - 1);
  localparam logic [4:0] RD_LD   = 5'(RD_CYC - 1);
  localparam logic [4:0] TURN_LD = 5'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  state_t           state;
  logic [4:0]       cnt;
  logic             owner;     // 0 = A, 1 = B
  logic             we_l;
  logic [WIDTH-1:0] wdata_l;
  logic             last_dir;  // 1 = last op was a write
  logic             last_b;    // last grant went to B

  logic             elig_a, elig_b, gnt, gnt_b, sel_we;
  logic [WIDTH-1:0] sel_wdata;

  // The requester being acked this cycle is masked so its stale req is not re-granted.
  always_comb begin
    elig_a    = req_a & ~ack_a;
    elig_b    = req_b & ~ack_b;
    gnt       = elig_a | elig_b;
    gnt_b     = elig_b & (~elig_a | ~last_b);
    sel_we    = gnt_b ? we_b : we_a;
    sel_wdata = gnt_b ? wdata_b : wdata_a;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= 1'b0;
      we_l     <= 1'b0;
      wdata_l  <= '0;
      last_dir <= 1'b0;
      last_b   <= 1'b1;
      pad_t    <= '1;
      pad_i    <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      busy     <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt) begin
            owner   <= gnt_b;
            last_b  <= gnt_b;
            we_l    <= sel_we;
            wdata_l <= sel_wdata;
            busy    <= 1'b1;
            if ((sel_we != last_dir) && (TURN_CYC > 0)) begin
              state <= TURN;
              cnt   <= TURN_LD;
            end else if (sel_we) begin
              state <= DRIVE;
              cnt   <= WR_LD;
              pad_t <= '0;
              pad_i <= sel_wdata;
            end else begin
              state <= SAMPLE;
              cnt   <= RD_LD;
            end
          end
        end
        TURN: begin
          if (cnt == 5'd0) begin
            if (we_l) begin
              state <= DRIVE;
              cnt   <= WR_LD;
              pad_t <= '0;
              pad_i <= wdata_l;
            end else begin
              state <= SAMPLE;
              cnt   <= RD_LD;
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DRIVE: begin
          if (cnt == 5'd0) begin
            state    <= IDLE;
            pad_t    <= '1;
            pad_i    <= '0;
            busy     <= 1'b0;
            last_dir <= 1'b1;
            if (owner) ack_b <= 1'b1;
            else       ack_a <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        SAMPLE: begin
          if (cnt == 5'd0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            last_dir <= 1'b0;
            if (owner) begin
              rdata_b <= pad_o;
              ack_b   <= 1'b1;
            end else begin
              rdata_a <= pad_o;
              ack_a   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iobuf_bus_ctrl.sv
// Directed bench for iobuf_bus_ctrl: ops queued as driven, checked against pads and acks as they complete.
module tb_iobuf_bus_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       req_a, we_a, ack_a, req_b, we_b, ack_b, busy;
  logic [7:0] wdata_a, rdata_a, wdata_b, rdata_b, pad_i, pad_t, pad_o;

  typedef struct {
    logic       owner;
    logic       we;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  iobuf_bus_ctrl #(.WIDTH(8), .WR_CYC(2), .RD_CYC(2), .TURN_CYC(1)) dut (
    .CLK(CLK), .RST(RST),
    .req_a(req_a), .we_a(we_a), .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .pad_i(pad_i), .pad_t(pad_t), .pad_o(pad_o), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic o, input logic w, input logic [7:0] d);
    exp_t x;
    x.owner = o;
    x.we    = w;
    x.data  = d;
    q.push_back(x);
  endtask

  // Bus and completion monitor; the queue front is always the op in flight.
  always @(negedge CLK) begin
    if (!RST) begin
      if (pad_t !== 8'h00) begin
        check("pad_t_released", pad_t, 8'hFF);
        check("pad_i_idle", pad_i, 8'h00);
      end else if (q.size() == 0) begin
        check("drive_unexpected", 8'(q.size()), 8'd1);
      end else begin
        check("drive_is_write", 8'(q[0].we), 8'd1);
        check("pad_i_drive", pad_i, q[0].data);
      end
      if (ack_a || ack_b) begin
        if (q.size() == 0) begin
          check("ack_unexpected", 8'({ack_a, ack_b}), 8'd0);
        end else begin
          e = q.pop_front();
          check("ack_owner", 8'({ack_a, ack_b}), e.owner ? 8'd1 : 8'd2);
          if (!e.we) check("rdata", e.owner ? rdata_b : rdata_a, e.data);
        end
      end
    end
  end

  initial begin
    int n;
    RST = 1'b1; req_a = 1'b1; we_a = 1'b0; wdata_a = 8'h00;
    req_b = 1'b0; we_b = 1'b0; wdata_b = 8'h00; pad_o = 8'h5A;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rst_pad_t", pad_t, 8'hFF);
      check("rst_pad_i", pad_i, 8'h00);
      check("rst_ack", 8'({ack_a, ack_b}), 8'd0);
      check("rst_rdata_a", rdata_a, 8'h00);
      check("rst_rdata_b", rdata_b, 8'h00);
      check("rst_busy", 8'(busy), 8'd0);
    end
    RST = 1'b0; push(1'b0, 1'b0, 8'h5A);
    tick; check("t1_grant_busy", 8'(busy), 8'd1);
    tick; check("t1_sample_busy", 8'(busy), 8'd1);
    tick; check("t1_ack_a", 8'(ack_a), 8'd1);
    req_a = 1'b0;
    tick; check("t1_idle_busy", 8'(busy), 8'd0); check("t1_ack_pulse", 8'(ack_a), 8'd0);

    // Write A after a read: turnaround then two drive cycles
    req_a = 1'b1; we_a = 1'b1; wdata_a = 8'hA5; push(1'b0, 1'b1, 8'hA5);
    tick; check("t2_turn_t", pad_t, 8'hFF); check("t2_turn_busy", 8'(busy), 8'd1);
    tick; check("t2_drv1_t", pad_t, 8'h00); check("t2_drv1_i", pad_i, 8'hA5);
    wdata_a = 8'hEE;
    tick; check("t2_drv2_t", pad_t, 8'h00); check("t2_drv2_i", pad_i, 8'hA5);
    tick; check("t2_ack_a", 8'(ack_a), 8'd1); check("t2_ack_t", pad_t, 8'hFF);
    check("t2_ack_i", pad_i, 8'h00);
    req_a = 1'b0;

    // Read B after a write: granted in A's ack cycle, one turnaround
    req_b = 1'b1; we_b = 1'b0; pad_o = 8'h3C; push(1'b1, 1'b0, 8'h3C);
    tick; check("t3_turn_busy", 8'(busy), 8'd1); check("t3_turn_t", pad_t, 8'hFF);
    tick; check("t3_smp1_t", pad_t, 8'hFF);
    tick; check("t3_smp2_t", pad_t, 8'hFF); check("t3_no_early_ack", 8'(ack_b), 8'd0);
    tick; check("t3_ack_b", 8'(ack_b), 8'd1); check("t3_rdata_b", rdata_b, 8'h3C);
    check("t3_rdata_a_held", rdata_a, 8'h5A);
    req_b = 1'b0; pad_o = 8'h77;
    tick;

    // Both reading continuously: B went last, so order is A,B,A,B
    req_a = 1'b1; we_a = 1'b0; req_b = 1'b1; we_b = 1'b0;
    push(1'b0, 1'b0, 8'h77); push(1'b1, 1'b0, 8'h77);
    push(1'b0, 1'b0, 8'h77); push(1'b1, 1'b0, 8'h77);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick;
      if (ack_a || ack_b) n++;
    end
    req_a = 1'b0; req_b = 1'b0;
    check("t4_ack_count", 8'(n), 8'd4);
    tick;

    // Writes A then B: one IDLE (ack) cycle between bursts, no turnaround
    req_a = 1'b1; we_a = 1'b1; wdata_a = 8'h11;
    req_b = 1'b1; we_b = 1'b1; wdata_b = 8'h22;
    push(1'b0, 1'b1, 8'h11); push(1'b1, 1'b1, 8'h22);
    tick; check("t5_turn_t", pad_t, 8'hFF);
    tick; check("t5_a1_i", pad_i, 8'h11);
    tick; check("t5_a2_i", pad_i, 8'h11);
    tick; check("t5_ack_a", 8'(ack_a), 8'd1); check("t5_gap_t", pad_t, 8'hFF);
    req_a = 1'b0;
    tick; check("t5_b1_t", pad_t, 8'h00); check("t5_b1_i", pad_i, 8'h22);
    tick; check("t5_b2_i", pad_i, 8'h22);
    tick; check("t5_ack_b", 8'(ack_b), 8'd1);
    req_b = 1'b0;
    tick;

    // Reset during the second drive cycle aborts the write without an ack
    req_a = 1'b1; we_a = 1'b1; wdata_a = 8'h44; push(1'b0, 1'b1, 8'h44);
    tick; check("t6_drv1_i", pad_i, 8'h44);
    tick; check("t6_drv2_t", pad_t, 8'h00);
    RST = 1'b1; req_a = 1'b0;
    tick;
    check("t6_rst_t", pad_t, 8'hFF); check("t6_rst_i", pad_i, 8'h00);
    check("t6_rst_busy", 8'(busy), 8'd0); check("t6_rst_ack", 8'(ack_a), 8'd0);
    check("t6_rst_rdata_a", rdata_a, 8'h00); check("t6_rst_rdata_b", rdata_b, 8'h00);
    q.delete();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick; check("t6_no_ack", 8'(ack_a), 8'd0); check("t6_idle_busy", 8'(busy), 8'd0);
    end

    // After reset A has priority again even though A was granted last
    req_a = 1'b1; we_a = 1'b0; req_b = 1'b1; we_b = 1'b0; pad_o = 8'h99;
    push(1'b0, 1'b0, 8'h99); push(1'b1, 1'b0, 8'h99);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      tick;
      if (ack_a) req_a = 1'b0;
      if (ack_b) req_b = 1'b0;
      if (ack_a || ack_b) n++;
    end
    req_a = 1'b0; req_b = 1'b0;
    check("t7_ack_count", 8'(n), 8'd2);
    tick; tick;
    check("queue_drained", 8'(q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
